// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the byte FIFO between the UART path
// and the calculator core.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO is distinguishable from empty.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Operation/data/status bundle for the FIFO; the producer/consumer drives
// through the master modport, the FIFO answers through the slave modport.
interface fifo_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::DEF_FIFO_DEPTH
);
    import fifo_pkg::*;

    logic                               E;
    logic                               R_WR;
    logic [DATA_WIDTH-1:0]              DATA_IN;
    logic [DATA_WIDTH-1:0]              DATA_OUT;
    logic                               FULL;
    logic                               EMPTY;
    logic [cnt_width(FIFO_DEPTH)-1:0]   COUNT;

    modport master (
        output E, R_WR, DATA_IN,
        input  DATA_OUT, FULL, EMPTY, COUNT
    );

    modport slave (
        input  E, R_WR, DATA_IN,
        output DATA_OUT, FULL, EMPTY, COUNT
    );

endinterface

// File: rtl/fifo_mem.sv
// Register array with a synchronous write port and an asynchronous read port;
// contents are deliberately left out of reset.
module fifo_mem #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEF_FIFO_DEPTH,
    parameter int ADDR_W     = fifo_pkg::ptr_width(fifo_pkg::DEF_FIFO_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: one operation per enabled edge, direction chosen by R_WR.
// Pointers, occupancy count, flags and the registered read data live here.
module fifo #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::DEF_FIFO_DEPTH
) (
    input  logic   CLK,
    input  logic   RST,
    fifo_if.slave  bus
);
    import fifo_pkg::*;

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Blocked operations (write when full, read when empty) are silently dropped.
    assign w_do_wr = bus.E && (bus.R_WR == OP_WRITE) && !w_full;
    assign w_do_rd = bus.E && (bus.R_WR == OP_READ)  && !w_empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_do_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.DATA_IN),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Pointers wrap by natural overflow since the depth is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count  <= r_count + CNT_W'(1);
        end else if (w_do_rd) begin
            r_data_out <= w_rd_data;
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            r_count    <= r_count - CNT_W'(1);
        end
    end

    assign bus.DATA_OUT = r_data_out;
    assign bus.FULL     = w_full;
    assign bus.EMPTY    = w_empty;
    assign bus.COUNT    = r_count;

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the FIFO: reset, ordering, fill/overflow, underflow,
// pointer wrap, enable gating and asynchronous mid-operation reset.
module tb_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        bus.E = 1'b1; bus.R_WR = 1'b1; bus.DATA_IN = d;
        tick();
        bus.E = 1'b0;
    endtask

    task automatic do_read();
        bus.E = 1'b1; bus.R_WR = 1'b0;
        tick();
        bus.E = 1'b0;
    endtask

    task automatic test_reset();
        bus.E = 1'b1; bus.R_WR = 1'b1; bus.DATA_IN = 8'h33;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0 || bus.COUNT !== 5'd0 || bus.DATA_OUT !== 8'h00) begin
                miscompares++;
                $display("FAIL reset[%0d]: empty=%b full=%b count=%0d dout=%h, want 1 0 0 00",
                         i, bus.EMPTY, bus.FULL, bus.COUNT, bus.DATA_OUT);
            end
        end
        bus.E = 1'b0;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_basic_order();
        logic [DW-1:0] vals [5] = '{8'hA5, 8'h5A, 8'h6A, 8'hA6, 8'h99};
        for (int i = 0; i < 5; i++) do_write(vals[i]);
        vectors++;
        if (bus.COUNT !== 5'd5 || bus.EMPTY !== 1'b0) begin
            miscompares++;
            $display("FAIL order_count: count=%0d empty=%b, want 5 0", bus.COUNT, bus.EMPTY);
        end
        for (int i = 0; i < 4; i++) begin
            do_read();
            vectors++;
            if (bus.DATA_OUT !== vals[i]) begin
                miscompares++;
                $display("FAIL order_read[%0d]: got %h want %h", i, bus.DATA_OUT, vals[i]);
            end
        end
        vectors++;
        if (bus.COUNT !== 5'd1 || bus.EMPTY !== 1'b0) begin
            miscompares++;
            $display("FAIL order_remain: count=%0d empty=%b, want 1 0", bus.COUNT, bus.EMPTY);
        end
        do_read();
        vectors++;
        if (bus.DATA_OUT !== 8'h99 || bus.EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL order_drain: dout=%h empty=%b, want 99 1", bus.DATA_OUT, bus.EMPTY);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            do_write(8'(i));
            if (i == DEPTH - 2) begin
                vectors++;
                if (bus.FULL !== 1'b0 || bus.COUNT !== 5'd15) begin
                    miscompares++;
                    $display("FAIL fill_15: full=%b count=%0d, want 0 15", bus.FULL, bus.COUNT);
                end
            end
        end
        vectors++;
        if (bus.FULL !== 1'b1 || bus.COUNT !== 5'd16 || bus.EMPTY !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: full=%b count=%0d empty=%b, want 1 16 0", bus.FULL, bus.COUNT, bus.EMPTY);
        end
        do_write(8'hFF);
        vectors++;
        if (bus.FULL !== 1'b1 || bus.COUNT !== 5'd16) begin
            miscompares++;
            $display("FAIL overflow: full=%b count=%0d, want 1 16", bus.FULL, bus.COUNT);
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_read();
            vectors++;
            if (bus.DATA_OUT !== 8'(i)) begin
                miscompares++;
                $display("FAIL fill_read[%0d]: got %h want %h", i, bus.DATA_OUT, 8'(i));
            end
            if (i == 0) begin
                vectors++;
                if (bus.FULL !== 1'b0 || bus.COUNT !== 5'd15) begin
                    miscompares++;
                    $display("FAIL unfull: full=%b count=%0d, want 0 15", bus.FULL, bus.COUNT);
                end
            end
        end
        vectors++;
        if (bus.EMPTY !== 1'b1 || bus.COUNT !== 5'd0) begin
            miscompares++;
            $display("FAIL fill_empty: empty=%b count=%0d, want 1 0", bus.EMPTY, bus.COUNT);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            do_read();
            vectors++;
            if (bus.DATA_OUT !== 8'h0F || bus.COUNT !== 5'd0 || bus.EMPTY !== 1'b1) begin
                miscompares++;
                $display("FAIL underflow[%0d]: dout=%h count=%0d empty=%b, want 0f 0 1",
                         i, bus.DATA_OUT, bus.COUNT, bus.EMPTY);
            end
        end
    endtask

    task automatic test_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) do_write(8'(8'h20 + pass * 8'h20 + i));
            vectors++;
            if (bus.COUNT !== 5'd10) begin
                miscompares++;
                $display("FAIL wrap_count[%0d]: got %0d want 10", pass, bus.COUNT);
            end
            for (int i = 0; i < 10; i++) begin
                do_read();
                vectors++;
                if (bus.DATA_OUT !== 8'(8'h20 + pass * 8'h20 + i)) begin
                    miscompares++;
                    $display("FAIL wrap_read[%0d][%0d]: got %h want %h",
                             pass, i, bus.DATA_OUT, 8'(8'h20 + pass * 8'h20 + i));
                end
            end
        end
        vectors++;
        if (bus.EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_empty: got %b want 1", bus.EMPTY);
        end
    endtask

    task automatic test_enable();
        bus.E = 1'b0; bus.R_WR = 1'b1; bus.DATA_IN = 8'h77;
        tick();
        vectors++;
        if (bus.COUNT !== 5'd0 || bus.EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_wr: count=%0d empty=%b, want 0 1", bus.COUNT, bus.EMPTY);
        end
        do_write(8'h11);
        bus.E = 1'b0; bus.R_WR = 1'b0;
        tick();
        vectors++;
        if (bus.COUNT !== 5'd1 || bus.DATA_OUT !== 8'h49) begin
            miscompares++;
            $display("FAIL enable_rd: count=%0d dout=%h, want 1 49", bus.COUNT, bus.DATA_OUT);
        end
        do_read();
        vectors++;
        if (bus.DATA_OUT !== 8'h11) begin
            miscompares++;
            $display("FAIL enable_data: got %h want 11", bus.DATA_OUT);
        end
    endtask

    task automatic test_async_reset();
        do_write(8'hC1);
        do_write(8'hC2);
        do_write(8'hC3);
        vectors++;
        if (bus.COUNT !== 5'd3) begin
            miscompares++;
            $display("FAIL pre_reset: count=%0d want 3", bus.COUNT);
        end
        // Now 1 unit past an edge; pulse reset well before the next one.
        #2 RST = 1'b0;
        #1;
        vectors++;
        if (bus.EMPTY !== 1'b1 || bus.FULL !== 1'b0 || bus.COUNT !== 5'd0 || bus.DATA_OUT !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: empty=%b full=%b count=%0d dout=%h, want 1 0 0 00",
                     bus.EMPTY, bus.FULL, bus.COUNT, bus.DATA_OUT);
        end
        #1 RST = 1'b1;
        do_write(8'h55);
        do_read();
        vectors++;
        if (bus.DATA_OUT !== 8'h55 || bus.EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: dout=%h empty=%b, want 55 1", bus.DATA_OUT, bus.EMPTY);
        end
    endtask

    initial begin
        bus.E = 1'b0; bus.R_WR = 1'b0; bus.DATA_IN = '0;
        test_reset();
        test_basic_order();
        test_fill();
        test_underflow();
        test_wrap();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
